noc_input_buffer: RTL
=====================

Name: noc_input_buffer

Overview:
- Per-input-port flit FIFO of the NoC router, directly upstream of the LBDR routing stage.
- Accepts flits from the link under credit-based flow control and presents the head flit's `empty`, `flit_id` and `dst_addr` to LBDR.
- Pops the head flit on a read grant from the downstream switch allocator.
- Tracks packet framing so `dst_addr` stays stable for BODY and TAIL flits of the packet in flight.

Parameters:
- DATA_WIDTH, 32, flit width in bits.
- DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
- PTR_W, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  router clock.
- rst  in  1  reset; one clock, reset is asynchronous and active-low.
- rx_valid  in  1  link flit valid.
- rx_flit  in  DATA_WIDTH  link flit.
- rd_en  in  1  allocator grant: pop the head flit.
- credit_out  out  1  one-cycle pulse per popped flit, returned to the upstream router.
- empty  out  1  FIFO empty (to LBDR).
- full  out  1  FIFO full.
- occupancy  out  PTR_W+1  stored flit count.
- head_flit  out  DATA_WIDTH  head entry (fall-through, to crossbar).
- flit_id  out  3  head_flit[31:29] (to LBDR).
- dst_addr  out  4  routing destination (to LBDR).
- proto_err  out  1  sticky framing error.
- ovf_err  out  1  sticky overflow error.

Behaviour:
- Flit format:
  - [31:29] flit_id: HEADER=3'b001, BODY=3'b010, TAIL=3'b100.
  - HEADER only: [28:25] dst_addr, [24:21] src_addr.
  - All remaining bits are payload.
- Reset (rst=0, asynchronous): pointers and occupancy 0, empty=1, full=0, credit_out=0, proto_err=0, ovf_err=0, FSM=IDLE, dst latch=0. Memory contents are don't-care.
- Write: rx_valid=1 and not full stores the flit at wr_ptr. occupancy increments on the next edge. The flit is visible at head_flit one cycle after it is written; there is no same-cycle bypass.
- Read: rd_en=1 and not empty pops the head. rd_en while empty is ignored: no pop, no credit, no error.
- Simultaneous write and read:
  - Not empty: both occur, occupancy unchanged.
  - Full: the write is accepted because a slot frees in the same cycle; full stays 1.
  - Empty: only the write occurs.
- Overflow: rx_valid while full with no valid read drops the flit and sets ovf_err. FIFO state is unchanged.
- Pointers wrap modulo DEPTH. full = (occupancy==DEPTH); empty = (occupancy==0).
- credit_out is registered: it pulses exactly 1 cycle after each pop edge and is never asserted otherwise.
- flit_id = head_flit[31:29] combinationally; its value is don't-care while empty.
- Framing FSM, evaluated on pops only:
  - IDLE + pop HEADER → PKT; latch head_flit[28:25].
  - PKT + pop BODY → stay PKT.
  - PKT + pop TAIL → IDLE.
  - IDLE + pop BODY/TAIL, PKT + pop HEADER, or any other flit_id value → set proto_err.
    - A HEADER popped in PKT still re-latches dst and stays in PKT.
    - An unknown id or an orphan BODY/TAIL leaves the state unchanged.
- dst_addr:
  - Head is HEADER: dst_addr = head_flit[28:25].
  - Otherwise: dst_addr = latched value.
- proto_err and ovf_err clear only on reset.
- Reset asserted mid-packet: all state is discarded immediately. No credit pulse is issued for flits lost.

Decomposition:
- Shared include parameters.sv: add HEADER, BODY and TAIL flit-id constants plus field-position constants FLIT_ID_MSB=31, DST_MSB=28, DST_LSB=25.
- Sub-module flit_fifo_mem: DEPTH×DATA_WIDTH register array with write port and asynchronous read port. The buffer wraps it with pointer, FSM and credit logic.

Test Plan:
- Reset then write HEADER(dst=4'hA), BODY, TAIL on consecutive cycles, rd_en=0 → occupancy=3; flit_id=001 and dst_addr=A the cycle after the first write; no credit_out.
- Pop all three with rd_en=1 → credit_out high 3 consecutive cycles, each 1 cycle after its pop; dst_addr=A while BODY/TAIL are at head; empty=1 after; FSM returns to IDLE; proto_err=0.
- Fill to DEPTH=4, then rx_valid+rd_en together → accepted, full stays 1, occupancy=4; next rx_valid alone → ovf_err=1, occupancy=4, head unchanged.
- Push BODY while IDLE and pop it → proto_err=1 and stays 1 through a following clean HEADER/TAIL packet.
- Stream 10 single-header/tail packets with dst 0..9 → FIFO ordering preserved across pointer wrap; each HEADER presents its own dst.
- rst pulsed low mid-cycle while occupancy=2 and state PKT → all outputs take reset values immediately, not at the next edge.

Source files
------------

// File: rtl/noc_input_buffer_pkg.sv
// noc_input_buffer_pkg: flit field layout and framing state shared by the input buffer
package noc_input_buffer_pkg;
  localparam logic [2:0] HEADER = 3'b001;
  localparam logic [2:0] BODY   = 3'b010;
  localparam logic [2:0] TAIL   = 3'b100;
  localparam int FLIT_ID_MSB = 31;
  localparam int DST_MSB     = 28;
  localparam int DST_LSB     = 25;
  typedef enum logic {IDLE, PKT} frame_state_e;
endpackage

// File: rtl/noc_input_buffer_flit_fifo_mem.sv
// flit_fifo_mem: DEPTH x DATA_WIDTH register array, one write port, asynchronous read port
module flit_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [PTR_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: per-port flit FIFO with credit return and packet framing check for LBDR
module noc_input_buffer
  import noc_input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_flit,
  input  logic                  rd_en,
  output logic                  credit_out,
  output logic                  empty,
  output logic                  full,
  output logic [PTR_W:0]        occupancy,
  output logic [DATA_WIDTH-1:0] head_flit,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  proto_err,
  output logic                  ovf_err
);
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic             credit_q, proto_q, proto_d, ovf_q;
  logic [3:0]       dst_q, dst_d;
  frame_state_e     state_q, state_d;
  logic             pop, push;
  assign empty = occ_q == '0;
  assign full  = occ_q == (PTR_W+1)'(DEPTH);
  assign pop   = rd_en & ~empty;
  // a pop frees a slot in the same edge, so a write into a full FIFO is still accepted
  assign push  = rx_valid & (~full | pop);
  flit_fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_flit),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_flit)
  );
  assign flit_id    = head_flit[FLIT_ID_MSB -: 3];
  assign dst_addr   = flit_id == HEADER ? head_flit[DST_MSB:DST_LSB] : dst_q;
  assign occupancy  = occ_q;
  assign credit_out = credit_q;
  assign proto_err  = proto_q;
  assign ovf_err    = ovf_q;
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    proto_d = proto_q;
    if (pop && flit_id == HEADER) begin
      state_d = PKT;
      dst_d   = head_flit[DST_MSB:DST_LSB];
      proto_d = proto_q | (state_q == PKT);
    end else if (pop && state_q == PKT && flit_id == TAIL) begin
      state_d = IDLE;
    end else if (pop && !(state_q == PKT && flit_id == BODY)) begin
      proto_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      credit_q <= 1'b0;
      proto_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dst_q    <= '0;
      state_q  <= IDLE;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q    <= occ_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      credit_q <= pop;
      proto_q  <= proto_d;
      ovf_q    <= ovf_q | (rx_valid & full & ~pop);
      dst_q    <= dst_d;
      state_q  <= state_d;
    end
  end
endmodule
